reg_file_sb: RTL

Parametrised successor to the processor's 8x16 register file: 2 registered read ports, 1 write port, generic width/depth. Adds same-edge write-to-read bypass and a per-register pending-write scoreboard (reserve at issue, clear at writeback) reporting operand hazards to the control unit. Sits between decode (selects, reservations) and writeback (data_d), updating on the falling clk edge like the existing register file.

---
 rtl/reg_file_sb.sv | 83 ++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with same-edge write bypass and a pending-write scoreboard.
// Latency: one falling clk edge for data/busy/pend_cnt; no backpressure; en=0 freezes all state.
// Optional: define ZERO_REG_EN to hard-wire register 0 to zero and never pending.
module reg_file_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] sel_a,
    input  logic [ADDR_W-1:0] sel_b,
    input  logic [ADDR_W-1:0] sel_d,
    input  logic [DATA_W-1:0] data_d,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_sel,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [ADDR_W:0]     cnt_next;
    logic                wr_ok;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;

    // Reservation is applied after the writeback clear so a re-issue to the same register wins.
    always_comb begin
        wr_ok        = we;
        pending_next = pending;
        if (we)
            pending_next[sel_d] = 1'b0;
        if (rsv_en)
            pending_next[rsv_sel] = 1'b1;
`ifdef ZERO_REG_EN
        if (sel_d == '0)
            wr_ok = 1'b0;
        pending_next[0] = 1'b0;
`endif
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, pending_next[i]};
    end

    // Register 0 is never written when hard-wired, so its reset value of zero also covers the bypass.
    always_comb begin
        rd_a = (wr_ok && (sel_a == sel_d)) ? data_d : regs[sel_a];
        rd_b = (wr_ok && (sel_b == sel_d)) ? data_d : regs[sel_b];
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pending  <= '0;
            data_a   <= '0;
            data_b   <= '0;
            busy_a   <= 1'b0;
            busy_b   <= 1'b0;
            pend_cnt <= '0;
        end else if (en) begin
            if (wr_ok)
                regs[sel_d] <= data_d;
            pending  <= pending_next;
            data_a   <= rd_a;
            data_b   <= rd_b;
            busy_a   <= pending_next[sel_a];
            busy_b   <= pending_next[sel_b];
            pend_cnt <= cnt_next;
        end
    end

endmodule
